// File: rtl/dsc_mul_n.sv
// dsc_mul_n: N-input deterministic stochastic-computing multiplier.
// Ports: clk, rst (async low), en (stall), start, a (packed operands),
//   busy, done (pulse), z (product), cycles (RUN cycles used).
module dsc_mul_n #(
   parameter int WIDTH      = 8,
   parameter int NUM_INPUTS = 2,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             start,
   input  logic [NUM_INPUTS*WIDTH-1:0]      a,
   output logic                             busy,
   output logic                             done,
   output logic [NUM_INPUTS*WIDTH-1:0]      z,
   output logic [NUM_INPUTS*WIDTH:0]        cycles
);

   localparam int NW = NUM_INPUTS * WIDTH;
   localparam logic [WIDTH-1:0] MAXV = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;

   logic [NUM_INPUTS-1:0][WIDTH-1:0] x;
   logic [NUM_INPUTS-1:0][WIDTH-1:0] ctr;
   logic [NW-1:0]                    acc;
   logic [NW:0]                      cyc;

   logic [NUM_INPUTS-1:0] carry;
   logic                  bit_on;
   logic                  last;
   logic                  any_zero;
   logic [NW-1:0]         acc_nxt;
   logic [NW:0]           cyc_nxt;

   // carry[i]: every counter below i sits at its maximum, so ctr[i]
   // advances this cycle (cascaded clock division).
   always_comb begin
      carry[0] = 1'b1;
      for (int i = 1; i < NUM_INPUTS; i++)
         carry[i] = carry[i-1] & (ctr[i-1] == MAXV);
      bit_on = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++)
         if (ctr[i] >= x[i]) bit_on = 1'b0;
      last = carry[NUM_INPUTS-1] & (ctr[NUM_INPUTS-1] == MAXV);
      // Once the top counter passes its operand, every later bit is 0.
      if (EARLY_EXIT)
         last = last | (carry[NUM_INPUTS-1] &
                (ctr[NUM_INPUTS-1] == x[NUM_INPUTS-1] - 1'b1));
      any_zero = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++)
         if (a[i*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
      acc_nxt = acc + NW'(bit_on);
      cyc_nxt = cyc + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         z      <= '0;
         cycles <= '0;
         x      <= '0;
         ctr    <= '0;
         acc    <= '0;
         cyc    <= '0;
      end else if (en) begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  x    <= a;
                  ctr  <= '0;
                  acc  <= '0;
                  cyc  <= '0;
                  busy <= 1'b1;
                  if (any_zero) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     z      <= '0;
                     cycles <= '0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= acc_nxt;
               cyc <= cyc_nxt;
               for (int i = 0; i < NUM_INPUTS; i++)
                  if (carry[i]) ctr[i] <= ctr[i] + 1'b1;
               if (last) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  z      <= acc_nxt;
                  cycles <= cyc_nxt;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dsc_mul_n.sv
// tb_dsc_mul_n: directed table-driven bench for dsc_mul_n over five
// parameter sets, plus stall, ignored-start and reset-abort sequences.
module tb_dsc_mul_n;

   logic clk;
   logic rst;
   logic en;
   logic [4:0] start_v;
   logic [4:0] busy_v;
   logic [4:0] done_v;

   logic [7:0]  a0, z0, a1, z1;
   logic [8:0]  c0, c1;
   logic [15:0] a2, z2;
   logic [16:0] c2;
   logic [8:0]  a3, z3, a4, z4;
   logic [9:0]  c3, c4;

   int total;
   int bad;

   dsc_mul_n #(.WIDTH(4), .NUM_INPUTS(2), .EARLY_EXIT(1'b0)) u0 (
      .clk(clk), .rst(rst), .en(en), .start(start_v[0]), .a(a0),
      .busy(busy_v[0]), .done(done_v[0]), .z(z0), .cycles(c0));
   dsc_mul_n #(.WIDTH(4), .NUM_INPUTS(2), .EARLY_EXIT(1'b1)) u1 (
      .clk(clk), .rst(rst), .en(en), .start(start_v[1]), .a(a1),
      .busy(busy_v[1]), .done(done_v[1]), .z(z1), .cycles(c1));
   dsc_mul_n #(.WIDTH(8), .NUM_INPUTS(2), .EARLY_EXIT(1'b0)) u2 (
      .clk(clk), .rst(rst), .en(en), .start(start_v[2]), .a(a2),
      .busy(busy_v[2]), .done(done_v[2]), .z(z2), .cycles(c2));
   dsc_mul_n #(.WIDTH(3), .NUM_INPUTS(3), .EARLY_EXIT(1'b0)) u3 (
      .clk(clk), .rst(rst), .en(en), .start(start_v[3]), .a(a3),
      .busy(busy_v[3]), .done(done_v[3]), .z(z3), .cycles(c3));
   dsc_mul_n #(.WIDTH(3), .NUM_INPUTS(3), .EARLY_EXIT(1'b1)) u4 (
      .clk(clk), .rst(rst), .en(en), .start(start_v[4]), .a(a4),
      .busy(busy_v[4]), .done(done_v[4]), .z(z4), .cycles(c4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cfg;
      int o0;
      int o1;
      int o2;
      int ez;
      int ec;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int wid(input int cfg);
      case (cfg)
         0, 1:    return 4;
         2:       return 8;
         default: return 3;
      endcase
   endfunction

   function automatic longint get_z(input int cfg);
      case (cfg)
         0:       return longint'(z0);
         1:       return longint'(z1);
         2:       return longint'(z2);
         3:       return longint'(z3);
         default: return longint'(z4);
      endcase
   endfunction

   function automatic longint get_c(input int cfg);
      case (cfg)
         0:       return longint'(c0);
         1:       return longint'(c1);
         2:       return longint'(c2);
         3:       return longint'(c3);
         default: return longint'(c4);
      endcase
   endfunction

   task automatic set_a(input int cfg, input int o0, input int o1,
                        input int o2);
      logic [31:0] p;
      int w;
      w = wid(cfg);
      p = 32'(o0) | (32'(o1) << w) | (32'(o2) << (2 * w));
      case (cfg)
         0:       a0 = p[7:0];
         1:       a1 = p[7:0];
         2:       a2 = p[15:0];
         3:       a3 = p[8:0];
         default: a4 = p[8:0];
      endcase
   endtask

   // Waits for done; n counts edges after the accepting edge.
   task automatic wait_done(input int cfg, output int n);
      n = 0;
      while (!done_v[cfg] && n < 20000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n;
      string nm;
      nm = $sformatf("v%0d", idx);
      @(negedge clk);
      chk({nm, "_pre_done"}, longint'(done_v[v.cfg]), 0);
      set_a(v.cfg, v.o0, v.o1, v.o2);
      start_v[v.cfg] = 1'b1;
      @(posedge clk);
      #1;
      start_v[v.cfg] = 1'b0;
      chk({nm, "_busy"}, longint'(busy_v[v.cfg]), 1);
      wait_done(v.cfg, n);
      chk({nm, "_latency"}, longint'(n), longint'(v.ec));
      chk({nm, "_done"}, longint'(done_v[v.cfg]), 1);
      chk({nm, "_z"}, get_z(v.cfg), longint'(v.ez));
      chk({nm, "_cycles"}, get_c(v.cfg), longint'(v.ec));
      @(posedge clk);
      #1;
      chk({nm, "_done_off"}, longint'(done_v[v.cfg]), 0);
      chk({nm, "_busy_off"}, longint'(busy_v[v.cfg]), 0);
      chk({nm, "_z_hold"}, get_z(v.cfg), longint'(v.ez));
   endtask

   initial begin
      int n;
      total   = 0;
      bad     = 0;
      rst     = 1'b0;
      en      = 1'b1;
      start_v = '0;
      a0 = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;

      tbl[0]  = '{0, 15, 15, 0, 225, 256};
      tbl[1]  = '{0, 1, 1, 0, 1, 256};
      tbl[2]  = '{0, 0, 15, 0, 0, 0};
      tbl[3]  = '{1, 15, 15, 0, 225, 240};
      tbl[4]  = '{1, 15, 1, 0, 15, 16};
      tbl[5]  = '{1, 5, 7, 0, 35, 112};
      tbl[6]  = '{1, 15, 0, 0, 0, 0};
      tbl[7]  = '{2, 0, 200, 0, 0, 0};
      tbl[8]  = '{2, 200, 0, 0, 0, 0};
      tbl[9]  = '{3, 7, 5, 3, 105, 512};
      tbl[10] = '{4, 7, 5, 3, 105, 192};
      tbl[11] = '{4, 1, 1, 1, 1, 64};
      tbl[12] = '{3, 2, 7, 6, 84, 512};
      tbl[13] = '{4, 2, 7, 6, 84, 384};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", longint'(busy_v), 0);
      chk("rst_done", longint'(done_v), 0);
      chk("rst_z0", get_z(0), 0);
      chk("rst_c3", get_c(3), 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 14; i++)
         run_vec(i, tbl[i]);

      // Stall mid-run plus a start pulse with other operands while busy.
      @(negedge clk);
      set_a(0, 9, 6, 0);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      set_a(0, 2, 2, 0);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("stall_busy", longint'(busy_v[0]), 1);
      en = 1'b1;
      wait_done(0, n);
      chk("stall_latency", longint'(n + 26), 261);
      chk("stall_z", get_z(0), 54);
      chk("stall_cycles", get_c(0), 256);
      en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("stall_done_hold", longint'(done_v[0]), 1);
      en = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_done_off", longint'(done_v[0]), 0);
      repeat (300) @(posedge clk);
      #1;
      chk("ignored_start_no_done", longint'(done_v[0]), 0);
      chk("ignored_start_idle", longint'(busy_v[0]), 0);

      // Reset in the middle of a run discards it.
      @(negedge clk);
      set_a(0, 15, 15, 0);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_busy", longint'(busy_v[0]), 0);
      chk("abort_done", longint'(done_v[0]), 0);
      chk("abort_z", get_z(0), 0);
      chk("abort_cycles", get_c(0), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (done_v[0]) n++;
      end
      chk("abort_no_done", longint'(n), 0);
      run_vec(100, '{0, 3, 4, 0, 12, 256});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dsc_mul_n.md
# dsc_mul_n

Parametrised deterministic stochastic-computing (DSC) multiplier: multiplies NUM_INPUTS unsigned WIDTH-bit operands exactly, using clock-division unary streams. Each operand's stream comes from comparing it against a cascaded counter. The streams are ANDed and the ones are accumulated into a binary result. This block is the N-input, mode-selectable successor of the 2-input 8-bit dsc_mul. It adds a start/done handshake, a stall enable, a zero-operand shortcut, an optional early-exit mode and a cycle-count output.

## Interface
- WIDTH, 8, bits per operand (≥2)
- NUM_INPUTS, 2, operand count (≥2)
- EARLY_EXIT, 0, 1 = stop once the top operand's stream can only produce zeros
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  stall control; 0 freezes all state, including counters and the FSM
- start  in  1  request; sampled in IDLE when en=1
- a  in  NUM_INPUTS*WIDTH  packed operands; operand i = a[i*WIDTH +: WIDTH]
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; z and cycles are valid
- z  out  NUM_INPUTS*WIDTH  product, held until the next accepted start
- cycles  out  NUM_INPUTS*WIDTH+1  number of RUN cycles used, held with z

## Operation
- FSM states: IDLE, RUN, DONE. Every register updates only when en=1.
- IDLE, start=1:
  - Latch operands into x[i].
  - Clear ctr[i], acc and cyc.
  - If any x[i]=0, go to DONE with acc=0 and cyc=0 (zero shortcut).
  - Otherwise go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - bit = AND over all i of (ctr[i] < x[i]).
  - acc += bit; cyc += 1.
  - ctr[0] increments every cycle.
  - ctr[i] (i>0) increments when ctr[0..i-1] are all 2^WIDTH−1. All counters wrap.
- RUN exit, natural: after the cycle in which every ctr[i] = 2^WIDTH−1. Run length is 2^(WIDTH*NUM_INPUTS) cycles.
- RUN exit, EARLY_EXIT=1: additionally exit after the cycle in which ctr[NUM_INPUTS−1] = x[NUM_INPUTS−1]−1 and all lower counters are at max. Run length is x[N−1]·2^(WIDTH·(N−1)).
- On RUN exit, go to DONE.
- DONE:
  - z ← acc, cycles ← cyc.
  - done=1 for exactly one en-cycle, then IDLE.
- Result equals the exact product of the operands. acc width NUM_INPUTS*WIDTH is sufficient because (2^W−1)^N < 2^(NW). cyc needs one extra bit to hold 2^(NW).
- start while busy: ignored. The new operands are not latched.
- a changing during RUN: no effect, because operands are latched.

## Timing
- Reset (rst=0, async): state=IDLE; busy, done, z, cycles, acc, cyc and all ctr = 0. An in-flight operation is discarded and no done is produced.
- start accepted at edge k:
  - busy=1 from k+1.
  - First RUN cycle is k+1.
  - With L RUN cycles (en high throughout), done=1 during cycle k+1+L, and z/cycles update at that same edge.
- Zero shortcut: done=1 in cycle k+1, with z=0 and cycles=0.
- en=0 in any state: outputs hold and done stays asserted if already high. Latency extends by exactly the number of stalled cycles; cycles does not count stalls.
- A new start can be accepted in the cycle after done (IDLE). There is no back-to-back start in the DONE cycle.

## Test plan
- WIDTH=4, N=2, EARLY_EXIT=0, a={15,15} → done after 256 RUN cycles, z=225, cycles=256.
- Same configuration with EARLY_EXIT=1 (top operand 15) → z=225, cycles=240. Operands {15,1} → z=15, cycles=16.
- WIDTH=8, N=2, operands {0,200} → done in the cycle after start, z=0, cycles=0, busy high for one cycle.
- WIDTH=3, N=3, operands {7,5,3} → z=105; cycles=512 with EARLY_EXIT=0 and 192 with EARLY_EXIT=1.
- WIDTH=4, N=2, {9,6}; hold en=0 for 5 cycles mid-run and pulse start during RUN with other operands → z=54, cycles=256, done 5 cycles later than unstalled, second start ignored.
- Assert rst low mid-run, release, start {3,4} → all outputs 0 during reset, no done for the aborted run, then z=12, cycles=256.
